// File: rtl/pwm_capture_pkg.sv
// pwm_capture_pkg: shared constants and phase encoding for the PWM capture block.
package pwm_capture_pkg;

    localparam int unsigned CNT_W_DEF    = 24;
    localparam int unsigned DUTY_W_DEF   = 8;
    // Full-scale duty code at the default duty width.
    localparam int unsigned DUTY_MAX     = (1 << DUTY_W_DEF) - 1;
    // Consecutive stable cycles required before the deglitched level follows the input.
    localparam int unsigned DEGLITCH_LEN = 4;

    typedef enum logic [1:0] {
        PH_IDLE = 2'd0,
        PH_HIGH = 2'd1,
        PH_LOW  = 2'd2
    } phase_t;

endpackage

// File: rtl/pwm_capture_frac_div.sv
// frac_div: restoring fractional divider, quo = floor(num * 2^DUTY_W / den) for num < den.
// The first quotient bit is resolved on the load edge, so busy spans DUTY_W cycles and
// done marks the last busy cycle, when quo already holds the final result.
// Requires DUTY_W >= 2.
module frac_div #(
    parameter int unsigned CNT_W  = 24,
    parameter int unsigned DUTY_W = 8
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  num,
    input  logic [CNT_W-1:0]  den,
    output logic              busy,
    output logic              done,
    output logic [DUTY_W-1:0] quo
);

    localparam int unsigned IT_W = $clog2(DUTY_W) + 1;

    logic [CNT_W-1:0] rem_q;
    logic [CNT_W-1:0] den_q;
    logic [IT_W-1:0]  it_q;
    logic [CNT_W-1:0] src_c;
    logic [CNT_W-1:0] dsrc_c;
    logic [CNT_W:0]   dbl_c;
    logic             bit_c;
    logic [CNT_W-1:0] rem_nxt_c;

    // One restoring step: double the remainder and subtract the divisor when it fits.
    always_comb begin
        src_c     = busy ? rem_q : num;
        dsrc_c    = busy ? den_q : den;
        dbl_c     = {src_c, 1'b0};
        bit_c     = (dbl_c >= {1'b0, dsrc_c});
        rem_nxt_c = bit_c ? CNT_W'(dbl_c - {1'b0, dsrc_c}) : CNT_W'(dbl_c);
    end

    // Iteration control and quotient shift register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rem_q <= '0;
            den_q <= '0;
            it_q  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            quo   <= '0;
        end else if (start && !busy) begin
            rem_q <= rem_nxt_c;
            den_q <= den;
            quo   <= DUTY_W'(bit_c);
            it_q  <= IT_W'(DUTY_W - 1);
            busy  <= 1'b1;
            done  <= 1'b0;
        end else if (busy) begin
            if (it_q != '0) begin
                rem_q <= rem_nxt_c;
                quo   <= DUTY_W'({quo, bit_c});
                it_q  <= it_q - IT_W'(1);
                done  <= (it_q == IT_W'(1));
            end else begin
                busy <= 1'b0;
                done <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time, period and normalised duty of an asynchronous PWM input.
// Optional build macro PWM_CAPTURE_DEGLITCH_EN inserts a 4-cycle stability filter after
// the synchroniser; when undefined the synchroniser output is used directly.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned DUTY_W      = DUTY_W_DEF,
    parameter int unsigned TIMEOUT_CYC = 2700000
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              pwm_in,
    output logic [CNT_W-1:0]  high_cnt,
    output logic [CNT_W-1:0]  period_cnt,
    output logic [DUTY_W-1:0] duty,
    output logic              valid,
    output logic              stuck,
    output logic              overrun
);

    localparam logic [CNT_W-1:0]  TIMEOUT_V = CNT_W'(TIMEOUT_CYC);
    localparam logic [DUTY_W-1:0] DUTY_FULL = '1;

    logic [1:0]        sync_q;
    logic              s_c;
    logic              prev_q;
    logic              rise_c;
    logic              fall_c;

    phase_t            phase_q, phase_d;
    logic [CNT_W-1:0]  hi_q, hi_d;
    logic [CNT_W-1:0]  per_q, per_d;
    logic [CNT_W-1:0]  idle_q, idle_d;
    logic              seen_q, seen_d;
    logic [CNT_W-1:0]  pend_high_q, pend_high_d;
    logic [CNT_W-1:0]  pend_per_q, pend_per_d;
    logic [CNT_W-1:0]  high_d, period_d;
    logic [DUTY_W-1:0] duty_d;
    logic              valid_d, stuck_d, overrun_d;
    logic              start_c;
    logic              timeout_c;

    logic              div_busy;
    logic              div_done;
    logic [DUTY_W-1:0] div_quo;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) sync_q <= 2'b00;
        else            sync_q <= {sync_q[0], pwm_in};
    end

`ifdef PWM_CAPTURE_DEGLITCH_EN
    localparam int unsigned DG_W = $clog2(DEGLITCH_LEN);

    logic            dg_q;
    logic [DG_W-1:0] dg_cnt_q;

    // Follow the synchronised level only after it has differed for DEGLITCH_LEN cycles.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            dg_q     <= 1'b0;
            dg_cnt_q <= '0;
        end else if (sync_q[1] == dg_q) begin
            dg_cnt_q <= '0;
        end else if (dg_cnt_q == DG_W'(DEGLITCH_LEN - 1)) begin
            dg_q     <= sync_q[1];
            dg_cnt_q <= '0;
        end else begin
            dg_cnt_q <= dg_cnt_q + DG_W'(1);
        end
    end

    assign s_c = dg_q;
`else
    assign s_c = sync_q[1];
`endif

    assign rise_c = s_c & ~prev_q;
    assign fall_c = ~s_c & prev_q;

    frac_div #(
        .CNT_W  (CNT_W),
        .DUTY_W (DUTY_W)
    ) u_div (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (start_c),
        .num       (hi_q),
        .den       (per_q),
        .busy      (div_busy),
        .done      (div_done),
        .quo       (div_quo)
    );

    // Phase state, counters and output registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            prev_q      <= 1'b0;
            phase_q     <= PH_IDLE;
            hi_q        <= '0;
            per_q       <= '0;
            idle_q      <= '0;
            seen_q      <= 1'b0;
            pend_high_q <= '0;
            pend_per_q  <= '0;
            high_cnt    <= '0;
            period_cnt  <= '0;
            duty        <= '0;
            valid       <= 1'b0;
            stuck       <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            prev_q      <= s_c;
            phase_q     <= phase_d;
            hi_q        <= hi_d;
            per_q       <= per_d;
            idle_q      <= idle_d;
            seen_q      <= seen_d;
            pend_high_q <= pend_high_d;
            pend_per_q  <= pend_per_d;
            high_cnt    <= high_d;
            period_cnt  <= period_d;
            duty        <= duty_d;
            valid       <= valid_d;
            stuck       <= stuck_d;
            overrun     <= overrun_d;
        end
    end

    // Phase transitions, period completion, divider hand-off and timeouts.
    always_comb begin
        phase_d     = phase_q;
        hi_d        = hi_q;
        per_d       = per_q;
        idle_d      = idle_q;
        seen_d      = seen_q;
        pend_high_d = pend_high_q;
        pend_per_d  = pend_per_q;
        high_d      = high_cnt;
        period_d    = period_cnt;
        duty_d      = duty;
        valid_d     = 1'b0;
        stuck_d     = stuck;
        overrun_d   = overrun;
        start_c     = 1'b0;
        timeout_c   = (per_q == TIMEOUT_V) && !div_busy;

        if (div_done) begin
            high_d   = pend_high_q;
            period_d = pend_per_q;
            duty_d   = div_quo;
            valid_d  = 1'b1;
        end

        if (rise_c) stuck_d = 1'b0;

        case (phase_q)
            PH_IDLE: begin
                if (rise_c) begin
                    phase_d = PH_HIGH;
                    hi_d    = CNT_W'(1);
                    per_d   = CNT_W'(1);
                    seen_d  = 1'b1;
                end else if (!seen_q) begin
                    if (idle_q == TIMEOUT_V) begin
                        stuck_d = 1'b1;
                        duty_d  = s_c ? DUTY_FULL : '0;
                        valid_d = 1'b1;
                        seen_d  = 1'b1;
                    end else begin
                        idle_d = sat_inc(idle_q);
                    end
                end
            end
            PH_HIGH: begin
                if (timeout_c) begin
                    stuck_d = 1'b1;
                    duty_d  = s_c ? DUTY_FULL : '0;
                    valid_d = 1'b1;
                    phase_d = PH_IDLE;
                end else if (fall_c) begin
                    per_d   = sat_inc(per_q);
                    phase_d = PH_LOW;
                end else begin
                    hi_d  = sat_inc(hi_q);
                    per_d = sat_inc(per_q);
                end
            end
            PH_LOW: begin
                if (rise_c) begin
                    if (div_busy) begin
                        overrun_d = 1'b1;
                    end else begin
                        start_c     = 1'b1;
                        pend_high_d = hi_q;
                        pend_per_d  = per_q;
                    end
                    hi_d    = CNT_W'(1);
                    per_d   = CNT_W'(1);
                    phase_d = PH_HIGH;
                end else if (timeout_c) begin
                    stuck_d = 1'b1;
                    duty_d  = s_c ? DUTY_FULL : '0;
                    valid_d = 1'b1;
                    phase_d = PH_IDLE;
                end else begin
                    per_d = sat_inc(per_q);
                end
            end
            default: phase_d = PH_IDLE;
        endcase
    end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: randomized PWM stimulus scored against an event-level reference model.
module tb_pwm_capture;
    import pwm_capture_pkg::*;

    localparam int unsigned CNT_W   = 24;
    localparam int unsigned DUTY_W  = 8;
    localparam int unsigned T_CYC   = 1000;
    localparam int          DIV_LAT = DUTY_W + 1;

    logic              sys_clk;
    logic              sys_rst_n;
    logic              pwm_in;
    logic [CNT_W-1:0]  high_cnt;
    logic [CNT_W-1:0]  period_cnt;
    logic [DUTY_W-1:0] duty;
    logic              valid;
    logic              stuck;
    logic              overrun;

    pwm_capture #(
        .CNT_W       (CNT_W),
        .DUTY_W      (DUTY_W),
        .TIMEOUT_CYC (T_CYC)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .pwm_in     (pwm_in),
        .high_cnt   (high_cnt),
        .period_cnt (period_cnt),
        .duty       (duty),
        .valid      (valid),
        .stuck      (stuck),
        .overrun    (overrun)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int cyc;
        int high;
        int period;
        int duty;
        bit stuck;
    } exp_t;

    exp_t expq[$];

    // Reference model state: works on edge times of the conditioned input.
    bit hist[$];
    int base;
    bit f_prev, s_prev;
    bit measuring, fall_seen, idle_armed;
    int last_rise, fall_cyc, div_free;
    int held_high, held_period;
    int ovr_first;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic bit raw_at(input int k);
        if (k < 2) return 1'b0;
        return hist[k-2];
    endfunction

    task automatic model_release();
        hist.delete();
        base        = cyc;
        f_prev      = 1'b0;
        s_prev      = 1'b0;
        measuring   = 1'b0;
        fall_seen   = 1'b0;
        idle_armed  = 1'b1;
        last_rise   = 0;
        fall_cyc    = 0;
        div_free    = 0;
        held_high   = 0;
        held_period = 0;
        ovr_first   = -1;
        expq.delete();
    endtask

    task automatic model_step(input bit w);
        int  k, n, h, p;
        bit  s, rise, fall;
        hist.push_back(w);
        k = hist.size() - 1;
        n = cyc;
`ifdef PWM_CAPTURE_DEGLITCH_EN
        begin
            bit all_new;
            all_new = 1'b1;
            for (int j = 1; j <= int'(DEGLITCH_LEN); j++)
                if (raw_at(k - j) == f_prev) all_new = 1'b0;
            s = all_new ? !f_prev : f_prev;
            f_prev = s;
        end
`else
        s = raw_at(k);
`endif
        rise = s && !s_prev;
        fall = !s && s_prev;
        if (rise) begin
            if (measuring && fall_seen) begin
                h = fall_cyc - last_rise;
                p = n - last_rise;
                if (n < div_free) begin
                    if (ovr_first < 0) ovr_first = n;
                end else begin
                    expq.push_back('{n + DIV_LAT, h, p, (h * (1 << DUTY_W)) / p, 1'b0});
                    held_high   = h;
                    held_period = p;
                    div_free    = n + DIV_LAT;
                end
            end
            measuring  = 1'b1;
            last_rise  = n;
            fall_seen  = 1'b0;
            idle_armed = 1'b0;
        end else if (measuring && (n - last_rise == int'(T_CYC))) begin
            expq.push_back('{n + 1, held_high, held_period, s ? int'(DUTY_MAX) : 0, 1'b1});
            measuring = 1'b0;
        end else if (idle_armed && (n - base == int'(T_CYC))) begin
            expq.push_back('{n + 1, held_high, held_period, s ? int'(DUTY_MAX) : 0, 1'b1});
            idle_armed = 1'b0;
        end else if (fall && measuring && !fall_seen) begin
            fall_seen = 1'b1;
            fall_cyc  = n;
        end
        s_prev = s;
    endtask

    task automatic tick(input bit w);
        @(posedge sys_clk);
        #1;
        if (!sys_rst_n) begin
            sys_rst_n = 1'b1;
            model_release();
        end
        pwm_in = w;
        model_step(w);
    endtask

    task automatic pattern(input int h, input int l, input int reps);
        repeat (reps) begin
            repeat (h) tick(1'b1);
            repeat (l) tick(1'b0);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_high_cnt"}, high_cnt, 0);
        chk({tag, "_period_cnt"}, period_cnt, 0);
        chk({tag, "_duty"}, duty, 0);
        chk({tag, "_valid"}, valid, 0);
        chk({tag, "_stuck"}, stuck, 0);
        chk({tag, "_overrun"}, overrun, 0);
    endtask

    task automatic do_reset(input int hold);
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b0;
        expq.delete();
        #1;
        check_zero("reset_mid");
        repeat (hold) @(posedge sys_clk);
    endtask

    // Monitor: score every valid pulse and flag any expected pulse that never arrived.
    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (valid) begin
                if (expq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_valid: got 1 expected 0 at cycle %0d", cyc);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("valid_cycle", cyc, e.cyc);
                    chk("high_cnt", high_cnt, e.high);
                    chk("period_cnt", period_cnt, e.period);
                    chk("duty", duty, e.duty);
                    chk("stuck", stuck, e.stuck);
                    chk("overrun", overrun, (ovr_first >= 0 && ovr_first < cyc) ? 1 : 0);
                end
            end else if (expq.size() > 0 && expq[0].cyc < cyc) begin
                exp_t e;
                e = expq.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL missing_valid: got none expected pulse at cycle %0d (now %0d)", e.cyc, cyc);
            end
        end
    end

    initial begin
        sys_rst_n = 1'b0;
        pwm_in    = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        check_zero("reset_init");

        // Idle timeout after reset with no edges.
        repeat (T_CYC + 100) tick(1'b0);

        // Nominal patterns.
        pattern(64, 192, 4);
        pattern(40, 60, 4);
        repeat (4) pattern(int'($urandom_range(10, 200)), int'($urandom_range(10, 200)), 3);

        // Stuck high, then recovery.
        repeat (T_CYC + 100) tick(1'b1);
        pattern(64, 192, 3);

        // Periods shorter than the divider latency.
        pattern(1, 2, 12);
        pattern(40, 60, 3);

        // Short low glitch inside the high phase.
        repeat (4) begin
            repeat (20) tick(1'b1);
            repeat (2)  tick(1'b0);
            repeat (28) tick(1'b1);
            repeat (50) tick(1'b0);
        end

        // Reset mid-period.
        repeat (30) tick(1'b1);
        do_reset(5);
        pattern(64, 192, 3);

        // Reset while the divider is working.
        pattern(40, 60, 2);
        repeat (9) tick(1'b1);
        do_reset(3);
        pattern(64, 192, 3);

        repeat (50) tick(1'b0);
        #2;
        chk("queue_drained", expq.size(), 0);
        chk("overrun_final", overrun, (ovr_first >= 0 && ovr_first < cyc) ? 1 : 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
